// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/resp encodings, FSM states, CLINT addresses and the misalignment check for the LSU AXI-lite master
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MTIME_LO = 32'h0200_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI = 32'h0200_BFFC;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == 2'd3 || (size == SZ_H && lo[0]) || (size == SZ_W && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load extract/extend (addr_lo,size,uns,rdata -> ld_data) and store lane shift/strobe (wdata -> st_data,st_strb)
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data,
  output logic [3:0]  st_strb
);
  logic [31:0] s;
  assign s = rdata >> {addr_lo, 3'b000};
  assign ld_data = size == SZ_B ? {{24{~uns & s[7]}}, s[7:0]} :
                   size == SZ_H ? {{16{~uns & s[15]}}, s[15:0]} : s;
  assign st_data = wdata << {addr_lo, 3'b000};
  assign st_strb = (size == SZ_B ? 4'h1 : size == SZ_H ? 4'h3 : 4'hF) << addr_lo;
endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: one-outstanding AXI-lite initiator; CPU req_*/resp_* side, registered AR/R and AW/W/B bus side, high = araddr[2]
module lsu_axi_master import lsu_pkg::*; #(
  parameter int TIMEOUT = 0,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              high,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [1:0]        rresp,
  input  logic [31:0]       rdata,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);
  state_t state, state_n;
  logic [31:0] cnt, rd_q, ld_data, st_data;
  logic [3:0] st_strb;
  logic [1:0] lo_q, size_q;
  logic uns_q, err_q, aw_done, w_done, idle, busy, to, mis, aw_ok, w_ok;
  assign idle = state == IDLE;
  assign busy = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
  assign to = TIMEOUT != 0 && busy && cnt == 32'(TIMEOUT - 1);
  assign mis = misaligned(req_size, req_addr[1:0]);
  assign aw_ok = aw_done | (awvalid & awready);
  assign w_ok = w_done | (wvalid & wready);
  assign req_ready = idle;
  assign resp_valid = state == DONE;
  assign resp_rdata = resp_valid ? rd_q : 32'd0;
  assign resp_err = resp_valid & err_q;
  lsu_align u_align (
    .addr_lo(idle ? req_addr[1:0] : lo_q),
    .size   (idle ? req_size : size_q),
    .uns    (uns_q),
    .rdata  (rdata),
    .wdata  (req_wdata),
    .ld_data(ld_data),
    .st_data(st_data),
    .st_strb(st_strb)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = mis ? DONE : req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (to || (arvalid && arready)) state_n = to ? DONE : RD_DATA;
      RD_DATA: if (to || rvalid) state_n = DONE;
      WR_REQ:  if (to || (aw_ok && w_ok)) state_n = to ? DONE : WR_RESP;
      WR_RESP: if (to || bvalid) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {arvalid, rready, awvalid, wvalid, bready, high, aw_done, w_done} <= '0;
      araddr <= '0;
      awaddr <= '0;
      wdata <= '0;
      wstrb <= '0;
      {lo_q, size_q, uns_q, err_q} <= '0;
      rd_q <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || !busy) ? 32'd0 : cnt + 32'd1;
      arvalid <= state_n == RD_ADDR;
      rready <= state_n == RD_DATA;
      bready <= state_n == WR_RESP;
      awvalid <= state_n == WR_REQ && !aw_ok;
      wvalid <= state_n == WR_REQ && !w_ok;
      aw_done <= state_n == WR_REQ && aw_ok;
      w_done <= state_n == WR_REQ && w_ok;
      if (idle && req_valid) begin
        {lo_q, size_q, uns_q, err_q} <= {req_addr[1:0], req_size, req_unsigned, mis};
        rd_q <= '0;
        if (!mis) begin
          high <= req_addr[2];
          if (req_wen) begin
            awaddr <= req_addr;
            wdata <= st_data;
            wstrb <= st_strb;
          end else
            araddr <= req_addr;
        end
      end else if (to)
        err_q <= 1'b1;
      else if (state == RD_DATA && rvalid)
        {err_q, rd_q} <= {rresp != OKAY, ld_data};
      else if (state == WR_RESP && bvalid)
        err_q <= bresp != OKAY;
    end
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: directed self-checking bench for lsu_axi_master with a hand-driven AXI-lite responder
module tb_lsu_axi_master;
  import lsu_pkg::*;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_wen = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, resp_valid, resp_err, high;
  logic [31:0] resp_rdata;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [31:0] araddr, awaddr, rdata = 0, wdata;
  logic [1:0] rresp = 0, bresp = 0;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [3:0] wstrb;
  int n_cmp = 0, n_bad = 0;
  lsu_axi_master #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .high(high),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] size, input logic uns);
    {req_wen, req_addr, req_wdata, req_size, req_unsigned, req_valid} = {wen, addr, wd, size, uns, 1'b1};
    tick();
    req_valid = 0;
  endtask
  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] data, input logic [1:0] resp);
    req(1'b0, addr, 32'd0, size, uns);
    tick();
    arready = 1;
    tick();
    {arready, rvalid, rdata, rresp} = {1'b0, 1'b1, data, resp};
    tick();
    rvalid = 0;
  endtask
  initial begin
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err, high}, 0);
    chk("rst_addr", araddr | awaddr, 0);
    chk("rst_data", {wdata, wstrb}, 0);
    chk("rst_rdata", resp_rdata, 0);
    tick();
    reset = 0;
    tick();
    req(1'b0, CLINT_MTIME_LO, 32'd0, SZ_W, 1'b0);
    chk("lw_t1_arvalid", arvalid, 1);
    chk("lw_t1_araddr", araddr, CLINT_MTIME_LO);
    chk("lw_t1_high", high, 0);
    tick();
    arready = 1;
    chk("lw_t2_arvalid", arvalid, 1);
    tick();
    {arready, rvalid, rdata, rresp} = {1'b0, 1'b1, 32'h0000_1234, OKAY};
    chk("lw_t3_arvalid", arvalid, 0);
    chk("lw_t3_rready", rready, 1);
    chk("lw_t3_resp_valid", resp_valid, 0);
    tick();
    rvalid = 0;
    chk("lw_t4_resp_valid", resp_valid, 1);
    chk("lw_t4_rdata", resp_rdata, 32'h0000_1234);
    chk("lw_t4_err", resp_err, 0);
    chk("lw_t4_req_ready", req_ready, 0);
    tick();
    chk("lw_t5_resp_valid", resp_valid, 0);
    chk("lw_t5_req_ready", req_ready, 1);
    load(CLINT_MTIME_HI, SZ_W, 1'b0, 32'hDEAD_BEEF, OKAY);
    chk("lw_hi_high", high, 1);
    chk("lw_hi_rdata", resp_rdata, 32'hDEAD_BEEF);
    tick();
    load(32'h8000_0003, SZ_B, 1'b0, 32'h80FF_0000, OKAY);
    chk("lb_valid", resp_valid, 1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_high", high, 0);
    tick();
    load(32'h8000_0003, SZ_B, 1'b1, 32'h80FF_0000, OKAY);
    chk("lbu_rdata", resp_rdata, 32'h0000_0080);
    tick();
    load(32'h8000_0002, SZ_H, 1'b1, 32'h80FF_0000, OKAY);
    chk("lhu_rdata", resp_rdata, 32'h0000_80FF);
    tick();
    load(32'h8000_0002, SZ_H, 1'b0, 32'h80FF_0000, OKAY);
    chk("lh_rdata", resp_rdata, 32'hFFFF_80FF);
    tick();
    load(32'h8000_0001, SZ_B, 1'b1, 32'h1234_5678, OKAY);
    chk("lbu1_rdata", resp_rdata, 32'h0000_0056);
    tick();
    load(32'h8000_0010, SZ_W, 1'b0, 32'h0, SLVERR);
    chk("rresp_valid", resp_valid, 1);
    chk("rresp_err", resp_err, 1);
    tick();
    req(1'b0, 32'h8000_0001, 32'd0, SZ_W, 1'b0);
    chk("mis_valid", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_arvalid", arvalid, 0);
    tick();
    chk("mis_t2_valid", resp_valid, 0);
    chk("mis_t2_arvalid", arvalid, 0);
    req(1'b1, 32'h8000_0001, 32'h1234, SZ_H, 1'b0);
    chk("mis_sh_err", {resp_valid, resp_err, awvalid, wvalid}, 4'b1100);
    tick();
    req(1'b1, 32'h8000_0003, 32'h1234, 2'd3, 1'b0);
    chk("size3_err", {resp_valid, resp_err, awvalid, wvalid}, 4'b1100);
    tick();
    req(1'b1, 32'h8000_0002, 32'h0000_ABCD, SZ_H, 1'b0);
    chk("sha_valids", {awvalid, wvalid}, 2'b11);
    chk("sha_awaddr", awaddr, 32'h8000_0002);
    chk("sha_wdata", wdata, 32'hABCD_0000);
    chk("sha_wstrb", wstrb, 4'hC);
    awready = 1;
    tick();
    awready = 0;
    chk("sha_t2_valids", {awvalid, wvalid}, 2'b01);
    tick();
    wready = 1;
    chk("sha_t3_wvalid", wvalid, 1);
    tick();
    wready = 0;
    chk("sha_t4", {awvalid, wvalid, bready}, 3'b001);
    {bvalid, bresp} = {1'b1, OKAY};
    tick();
    bvalid = 0;
    chk("sha_resp", {resp_valid, resp_err}, 2'b10);
    chk("sha_rdata", resp_rdata, 0);
    tick();
    chk("sha_once", resp_valid, 0);
    req(1'b1, 32'h8000_0002, 32'h0000_ABCD, SZ_H, 1'b0);
    wready = 1;
    tick();
    wready = 0;
    chk("shb_t2_valids", {awvalid, wvalid, bready}, 3'b100);
    awready = 1;
    tick();
    awready = 0;
    chk("shb_t3", {awvalid, wvalid, bready, resp_valid}, 4'b0010);
    {bvalid, bresp} = {1'b1, OKAY};
    tick();
    bvalid = 0;
    chk("shb_resp", {resp_valid, resp_err}, 2'b10);
    tick();
    chk("shb_once", resp_valid, 0);
    req(1'b1, 32'h8000_0002, 32'h0000_ABCD, SZ_H, 1'b0);
    {awready, wready} = 2'b11;
    tick();
    {awready, wready} = 2'b00;
    chk("shc_t2", {awvalid, wvalid, bready}, 3'b001);
    tick();
    chk("shc_t3_wait", {bready, resp_valid}, 2'b10);
    {bvalid, bresp} = {1'b1, SLVERR};
    tick();
    bvalid = 0;
    chk("shc_resp", {resp_valid, resp_err}, 2'b11);
    tick();
    chk("shc_once", resp_valid, 0);
    req(1'b1, 32'h8000_0003, 32'h0000_00A5, SZ_B, 1'b0);
    chk("sb_wdata", wdata, 32'hA500_0000);
    chk("sb_wstrb", wstrb, 4'h8);
    {awready, wready} = 2'b11;
    tick();
    {awready, wready} = 2'b00;
    {bvalid, bresp} = {1'b1, OKAY};
    tick();
    bvalid = 0;
    chk("sb_resp", {resp_valid, resp_err}, 2'b10);
    tick();
    req(1'b0, 32'h8000_0020, 32'd0, SZ_W, 1'b0);
    chk("to_t1_arvalid", arvalid, 1);
    for (int i = 0; i < 7; i++) tick();
    chk("to_t8", {arvalid, resp_valid}, 2'b10);
    tick();
    chk("to_t9_resp", {resp_valid, resp_err}, 2'b11);
    chk("to_t9_arvalid", arvalid, 0);
    tick();
    chk("to_t10", {resp_valid, req_ready, arvalid}, 3'b010);
    req(1'b0, 32'h8000_0004, 32'd0, SZ_W, 1'b0);
    tick();
    arready = 1;
    tick();
    arready = 0;
    chk("rst_mid_rready", rready, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid", {req_ready, rready, resp_valid, arvalid}, 4'b1000);
    tick();
    chk("rst_mid_noresp", {resp_valid, req_ready}, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI-lite initiator for the load/store unit. It turns one CPU memory request (load or store; byte, half or word) into AXI-lite AR/R or AW/W/B transactions toward the crossbar and its responders (CLINT, SRAM, UART). It returns sign- or zero-extended load data, or store completion, with an error flag. Single outstanding transaction; it sits between the EXU/LSU stage and the bus.

Parameters:
TIMEOUT, 0, cycles to wait on any single channel handshake before aborting with error; 0 disables the timeout.
ADDR_W, 32, address width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  block idle and able to accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_unsigned  in  1  load zero-extends when 1
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  bus error, misalignment or timeout
high  out  1  mirrors araddr[2]; word select for the 64-bit CLINT counter
arvalid, arready, araddr, rvalid, rready, rresp[1:0], rdata[31:0]  out/in/out/in/out/in/in  AXI-lite read channels
awvalid, awready, awaddr, wvalid, wready, wdata[31:0], wstrb[3:0], bvalid, bready, bresp[1:0]  out/in/out/out/in/out/out/in/out/in  AXI-lite write channels

Behaviour:
- Reset: state IDLE. req_ready=1. All valid outputs, rready, bready, resp_valid, resp_err and high are 0. Addresses, wdata, wstrb and resp_rdata are 0. Reset mid-transaction drops the transaction without any response.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid:
  - Latch the request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3 -> DONE with err=1 and no bus activity.
  - Otherwise a load goes to RD_ADDR and a store goes to WR_REQ.
- All bus outputs are registered. arvalid/awvalid/wvalid rise the cycle after acceptance.
- RD_ADDR: arvalid=1 and araddr=latched address (full byte address) are held stable until arvalid&&arready. Then go to RD_DATA.
- RD_DATA: rready=1 continuously, because the responder's rvalid may be a single-cycle pulse. On rvalid:
  - Capture rdata.
  - err = (rresp!=0).
  - Go to DONE.
- Load extraction: shift rdata right by 8*addr[1:0]. Keep 8, 16 or 32 bits per size. Sign-extend unless req_unsigned.
- WR_REQ: awvalid and wvalid are asserted together and each drops independently on its own handshake.
  - wdata = req_wdata shifted left by 8*addr[1:0].
  - wstrb = (1/3/F for size 0/1/2) shifted left by addr[1:0].
  - When both handshakes are complete (same or different cycles), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, err = (bresp!=0), then go to DONE.
- DONE: resp_valid=1 for exactly one cycle with resp_rdata and resp_err. Then go to IDLE; req_ready reasserts in the following cycle.
- Timeout (TIMEOUT>0): a counter is cleared on every state entry and increments every cycle spent in RD_ADDR, RD_DATA, WR_REQ or WR_RESP. Reaching TIMEOUT deasserts all valids and readies and goes to DONE with err=1.
- Latency with a responder that asserts arready one cycle after arvalid and rvalid one cycle after that: request accepted in cycle T, arvalid in T+1, arready in T+2, rvalid in T+3, resp_valid in T+4.
- high is updated together with araddr/awaddr.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W
  - AXI resp codes OKAY/SLVERR/DECERR
  - the FSM state enum
  - CLINT base address constants, for bench use.
- One natural sub-module, lsu_align. It is purely combinational and does load extract/extend plus store shift/strobe generation.

Test Plan:
- Word load at 0x0200_BFF8 with a CLINT-like responder returning 0x0000_1234 -> arvalid in T+1, resp_valid in T+4, rdata 0x0000_1234, err 0, high 0. At 0x0200_BFFC: high=1.
- lb at addr offset 3 with bus data 0x80FF_0000, signed -> 0xFFFF_FF80; lbu -> 0x0000_0080; lhu at offset 2 -> 0x0000_80FF.
- sh of 0x0000_ABCD at offset 2 -> wdata 0xABCD_0000, wstrb 0xC. Cover three cases: awready before wready by 2 cycles, wready first, and both at once -> exactly one resp_valid after bvalid.
- lw at 0x...01 -> resp_valid the cycle after acceptance, err 1, arvalid never asserted.
- rresp=2'b10 -> err 1. TIMEOUT=8 with arready stuck at 0 -> resp_valid with err 1 eight cycles after arvalid rises, and arvalid then 0.
- Reset asserted in RD_DATA -> next cycle req_ready=1, rready=0, and no resp_valid.
